// File: rtl/alu_issue_seq_if.sv
// Handshake bundle for alu_issue_seq: instruction stream in, result stream out.
// master = producer/consumer side, slave = the issue stage.
interface alu_issue_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_opcode;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_res;
  logic [3:0] out_opcode;
  logic       out_err;

  modport master (
    output in_valid, in_opcode, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_res, out_opcode, out_err
  );

  modport slave (
    input  in_valid, in_opcode, in_a, in_b, out_ready,
    output in_ready, out_valid, out_res, out_opcode, out_err
  );
endinterface

// File: rtl/alu_issue_seq.sv
// Issue stage in front of the 8-bit ALU: instruction FIFO, IDLE/EXEC/CAPT/HOLD sequencer,
// result hold register. Optional macro ALU_ISSUE_DIV0_TRAP_EN traps DIV by zero locally.
module alu_issue_seq #(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  alu_issue_seq_if.slave          bus,
  output logic [3:0]              alu_opcode,
  output logic [7:0]              alu_a,
  output logic [7:0]              alu_b,
  input  logic [7:0]              alu_res,
  output logic [$clog2(DEPTH):0]  level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [3:0] OP_DIV = 4'b0011;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } instr_t;

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, HOLD} state_t;

  state_t          state_q, state_d;
  instr_t          mem_q [DEPTH];
  instr_t          mem_d [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [3:0]      alu_op_q, alu_op_d;
  logic [7:0]      alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic            out_valid_q, out_valid_d, out_err_q, out_err_d;
  logic [7:0]      out_res_q, out_res_d;
  logic [3:0]      out_opcode_q, out_opcode_d;

  logic   push, pop, nonempty, hs, load, trap;
  instr_t head;

  assign bus.in_ready = (level_q < FULL_LVL) && rst_n;
  assign push         = bus.in_valid && bus.in_ready;
  assign head         = mem_q[rptr_q];
  assign nonempty     = (level_q != '0);
  assign hs           = (state_q == HOLD) && out_valid_q && bus.out_ready;
  assign load         = nonempty && ((state_q == IDLE) || hs);

`ifdef ALU_ISSUE_DIV0_TRAP_EN
  assign trap = (head.op == OP_DIV) && (head.b == 8'h00);
`else
  assign trap = 1'b0;
`endif

  // FIFO storage and pointers; pointer arithmetic wraps because DEPTH is a power of two.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    if (push) begin
      mem_d[wptr_q] = '{op: bus.in_opcode, a: bus.in_a, b: bus.in_b};
      wptr_d        = wptr_q + AW'(1);
    end
    if (pop) rptr_d = rptr_q + AW'(1);
    level_d = level_q + LW'(push) - LW'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (nonempty) state_d = trap ? HOLD : EXEC;
      EXEC:    state_d = CAPT;
      CAPT:    state_d = HOLD;
      HOLD:    if (hs) state_d = nonempty ? (trap ? HOLD : EXEC) : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pop          = load;
    alu_op_d     = alu_op_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    out_valid_d  = out_valid_q;
    out_res_d    = out_res_q;
    out_opcode_d = out_opcode_q;
    out_err_d    = out_err_q;
    if (state_q == CAPT) begin
      out_valid_d  = 1'b1;
      out_res_d    = alu_res;
      out_opcode_d = alu_op_q;
      out_err_d    = 1'b0;
    end
    if (hs) out_valid_d = 1'b0;
    // A trapped DIV never reaches the ALU; its result is produced here directly.
    if (load) begin
      if (trap) begin
        out_valid_d  = 1'b1;
        out_res_d    = 8'hFF;
        out_opcode_d = OP_DIV;
        out_err_d    = 1'b1;
      end else begin
        alu_op_d = head.op;
        alu_a_d  = head.a;
        alu_b_d  = head.b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      level_q      <= '0;
      alu_op_q     <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      out_valid_q  <= 1'b0;
      out_res_q    <= '0;
      out_opcode_q <= '0;
      out_err_q    <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      level_q      <= level_d;
      alu_op_q     <= alu_op_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      out_valid_q  <= out_valid_d;
      out_res_q    <= out_res_d;
      out_opcode_q <= out_opcode_d;
      out_err_q    <= out_err_d;
    end
  end

  // Storage needs no reset: entries are only read once written behind the reset pointers.
  always_ff @(posedge clk) mem_q <= mem_d;

  assign alu_opcode     = alu_op_q;
  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_res    = out_res_q;
  assign bus.out_opcode = out_opcode_q;
  assign bus.out_err    = out_err_q;
  assign level          = level_q;
endmodule

// File: tb/tb_alu_issue_seq.sv
// Bench for alu_issue_seq: ALU stub, in-order result scoreboard, vector table and corner sequences.
module tb_alu_issue_seq;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] alu_opcode;
  logic [7:0] alu_a, alu_b;
  logic [7:0] alu_res = 8'h00;
  logic [$clog2(DEPTH):0] level;

  alu_issue_seq_if bus();

  alu_issue_seq #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_res(alu_res), .level(level)
  );

  always #5 clk = ~clk;

  // Bench ALU: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 NOT, 15 LTH.
  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a * b;
      4'd3:    r = (b == 8'h00) ? 8'h00 : a / b;
      4'd4:    r = a & b;
      4'd5:    r = a | b;
      4'd6:    r = a ^ b;
      4'd7:    r = ~a;
      4'd15:   r = {7'd0, a < b};
      default: r = a ^ b ^ {4'h0, op};
    endcase
    return r;
  endfunction

  always @(posedge clk) alu_res <= alu_f(alu_opcode, alu_a, alu_b);

  typedef struct {
    logic [3:0] op;
    logic [7:0] res;
    logic       err;
  } exp_t;

  function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.op = op;
    e.res = alu_f(op, a, b);
    e.err = 1'b0;
`ifdef ALU_ISSUE_DIV0_TRAP_EN
    if (op == 4'd3 && b == 8'h00) begin
      e.res = 8'hFF;
      e.err = 1'b1;
    end
`endif
    return e;
  endfunction

  int checks = 0, errors = 0, cyc = 0, hs_cnt = 0;
  int hs_cyc[$];
  exp_t expq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: inputs/outputs sampled mid-cycle reflect the handshakes of the next edge.
  logic       hold_pend = 1'b0;
  logic [7:0] h_res;
  logic [3:0] h_op;
  logic       h_err;
  exp_t       mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      expq.delete();
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", bus.out_valid, 1);
        chk("hold_res", bus.out_res, h_res);
        chk("hold_op", bus.out_opcode, h_op);
        chk("hold_err", bus.out_err, h_err);
      end
      if (bus.out_valid && bus.out_ready) begin
        hs_cnt++;
        hs_cyc.push_back(cyc);
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_result: got res %0h with no outstanding op", bus.out_res);
        end else begin
          mon_e = expq.pop_front();
          chk("sb_res", bus.out_res, mon_e.res);
          chk("sb_op", bus.out_opcode, mon_e.op);
          chk("sb_err", bus.out_err, mon_e.err);
        end
      end
      if (bus.in_valid && bus.in_ready) expq.push_back(model(bus.in_opcode, bus.in_a, bus.in_b));
      hold_pend = bus.out_valid && !bus.out_ready;
      h_res = bus.out_res;
      h_op  = bus.out_opcode;
      h_err = bus.out_err;
    end
  end

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called just after a rising edge; returns 1ns after the edge that accepted the word.
  task automatic push(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_opcode = op;
    bus.in_a = a;
    bus.in_b = b;
    while (!bus.in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("push_accept", bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!bus.out_valid && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk("valid_timeout", bus.out_valid, 1);
  endtask

  task automatic wait_hs(input int target);
    int t = 0;
    while (hs_cnt < target && t < 80) begin
      @(negedge clk);
      t++;
    end
    chk("hs_count", hs_cnt, target);
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       err;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, n;
    logic [3:0] pop_;
    logic [7:0] pa, pb;

    tbl[0] = '{4'd0,  8'h12, 8'h34, 8'h46, 1'b0};
    tbl[1] = '{4'd1,  8'h05, 8'h07, 8'hFE, 1'b0};
    tbl[2] = '{4'd4,  8'hF0, 8'h3C, 8'h30, 1'b0};
    tbl[3] = '{4'd5,  8'h0F, 8'h30, 8'h3F, 1'b0};
    tbl[4] = '{4'd6,  8'hFF, 8'h0F, 8'hF0, 1'b0};
    tbl[5] = '{4'd2,  8'h10, 8'h10, 8'h00, 1'b0};
    tbl[6] = '{4'd3,  8'h09, 8'h03, 8'h03, 1'b0};
    tbl[7] = '{4'd15, 8'h03, 8'h05, 8'h01, 1'b0};
`ifdef ALU_ISSUE_DIV0_TRAP_EN
    tbl[8] = '{4'd3,  8'h09, 8'h00, 8'hFF, 1'b1};
`else
    tbl[8] = '{4'd3,  8'h09, 8'h00, 8'h00, 1'b0};
`endif

    bus.in_valid = 1'b0;
    bus.in_opcode = 4'd0;
    bus.in_a = 8'h00;
    bus.in_b = 8'h00;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_alu", {alu_opcode, alu_a, alu_b}, 0);
    chk("rst_out", {bus.out_res, bus.out_opcode, bus.out_err}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_neg(1);
    chk("ready_after_rst", bus.in_ready, 1);
    @(posedge clk); #1;

    // Single ADD latency: alu_* at N+1, out_valid after N+3
    push(4'd0, 8'h12, 8'h34);
    wait_neg(2);
    chk("lat_alu", {alu_opcode, alu_a, alu_b}, {4'd0, 8'h12, 8'h34});
    wait_neg(1);
    chk("lat_valid_early", bus.out_valid, 0);
    wait_neg(1);
    chk("lat_valid", bus.out_valid, 1);
    chk("lat_res", bus.out_res, 8'h46);
    chk("lat_op", bus.out_opcode, 4'd0);
    wait_neg(1);
    chk("lat_valid_drop", bus.out_valid, 0);

    // Vector table, one op at a time
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      pop_ = alu_opcode;
      pa = alu_a;
      pb = alu_b;
      push(tbl[i].op, tbl[i].a, tbl[i].b);
      wait_valid();
      chk("tbl_res", bus.out_res, tbl[i].res);
      chk("tbl_op", bus.out_opcode, tbl[i].op);
      chk("tbl_err", bus.out_err, tbl[i].err);
      if (tbl[i].err) chk("tbl_alu_kept", {alu_opcode, alu_a, alu_b}, {pop_, pa, pb});
      else            chk("tbl_alu", {alu_opcode, alu_a, alu_b}, {tbl[i].op, tbl[i].a, tbl[i].b});
      wait_neg(1);
    end

`ifdef ALU_ISSUE_DIV0_TRAP_EN
    // Trap latency: one cycle from load event to out_valid
    @(posedge clk); #1;
    push(4'd3, 8'h09, 8'h00);
    wait_neg(2);
    chk("trap_valid", bus.out_valid, 1);
    chk("trap_err", bus.out_err, 1);
    wait_neg(1);
`endif

    // Back-to-back AND then SUB: results 3 cycles apart
    @(posedge clk); #1;
    base = hs_cnt;
    push(4'd4, 8'hF0, 8'h3C);
    push(4'd1, 8'h05, 8'h07);
    wait_hs(base + 2);
    n = hs_cyc.size();
    chk("b2b_spacing", hs_cyc[n-1] - hs_cyc[n-2], 3);

    // Backpressure: fill FIFO behind a held result
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(4'(i), 8'(8'h20 + i), 8'(8'h03 + i));
    wait_neg(1);
    chk("bp_level", level, 4);
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_valid", bus.out_valid, 1);
    wait_neg(3);
    chk("bp_level_stall", level, 4);
    @(posedge clk); #1;
    base = hs_cnt;
    bus.out_ready = 1'b1;
    wait_neg(2);
    chk("bp_level_pop", level, 3);
    chk("bp_ready_back", bus.in_ready, 1);
    wait_hs(base + 5);
    n = hs_cyc.size();
    for (int k = 1; k < 5; k++) chk("bp_spacing", hs_cyc[n-k] - hs_cyc[n-k-1], 3);

    // Reset while holding a result with two buffered ops
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    push(4'd0, 8'h01, 8'h01);
    push(4'd0, 8'h02, 8'h02);
    push(4'd0, 8'h03, 8'h03);
    wait_neg(2);
    chk("rh_level", level, 2);
    chk("rh_valid", bus.out_valid, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rh_out_valid", bus.out_valid, 0);
    chk("rh_level0", level, 0);
    chk("rh_alu", {alu_opcode, alu_a, alu_b}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    base = hs_cnt;
    wait_neg(20);
    chk("rh_no_results", hs_cnt, base);
    chk("rh_idle_valid", bus.out_valid, 0);

    // Randomized traffic against the scoreboard
    repeat (800) begin
      @(posedge clk); #1;
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_opcode = 4'($urandom_range(0, 15));
      bus.in_a = 8'($urandom_range(0, 255));
      bus.in_b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 80 && expq.size() != 0; t++) @(negedge clk);
    wait_neg(2);
    chk("drain_empty", expq.size(), 0);
    chk("drain_level", level, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
